// File: rtl/move_sequencer_pkg.sv
// ============================================================================
// Module : move_sequencer_pkg
// Brief  : Shared types for the per-turn move sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package move_sequencer_pkg;

  localparam int DEFAULT_N_CELLS = 9;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_WRITE  = 3'd2,
    S_SCAN   = 3'd3,
    S_NOTIFY = 3'd4,
    S_DONE   = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_P1    = 2'd1,
    CELL_P2    = 2'd2
  } cell_code_t;

  // Board encoding of a move owner (player_id 0 -> P1, 1 -> P2).
  function automatic cell_code_t owner_code(input logic player);
    return player ? CELL_P2 : CELL_P1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/move_sequencer_if.sv
// ============================================================================
// Module : move_sequencer_if
// Brief  : Game-FSM / board-register bundle seen by the move sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface move_sequencer_if #(
  parameter int N_CELLS      = 9,
  parameter int TURN_SECONDS = 10
) ();

  localparam int CW = $clog2(N_CELLS);
  localparam int SW = $clog2(TURN_SECONDS + 1);

  logic               turn_active;
  logic               player_id;
  logic               sel_valid;
  logic [CW-1:0]      sel_cell;
  logic [N_CELLS-1:0] board_occ;
  logic               wr_en;
  logic [CW-1:0]      wr_cell;
  logic               wr_player;
  logic               player_mov;
  logic               timer_out;
  logic               sel_err;
  logic [SW-1:0]      seconds_left;

  modport master (
    output turn_active, player_id, sel_valid, sel_cell, board_occ,
    input  wr_en, wr_cell, wr_player, player_mov, timer_out, sel_err, seconds_left
  );

  modport slave (
    input  turn_active, player_id, sel_valid, sel_cell, board_occ,
    output wr_en, wr_cell, wr_player, player_mov, timer_out, sel_err, seconds_left
  );

endinterface

`default_nettype wire

// File: rtl/move_sequencer_turn_timer.sv
// ============================================================================
// Module : turn_timer
// Brief  : Per-second prescaler plus turn seconds countdown.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module turn_timer #(
  parameter int SEC_CYCLES   = 50_000_000,
  parameter int TURN_SECONDS = 10,
  parameter int SW           = $clog2(TURN_SECONDS + 1)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          load,
  input  wire logic          en,
  output logic      [SW-1:0] seconds_left,
  output logic               expired
);

  localparam int              PW         = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
  localparam logic [PW-1:0]   C_PRE_MAX  = PW'(SEC_CYCLES - 1);
  localparam logic [SW-1:0]   C_SEC_LOAD = SW'(TURN_SECONDS);

  logic [PW-1:0] r_pre;
  logic [SW-1:0] r_sec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
      r_sec <= '0;
    end else if (load) begin
      r_pre <= C_PRE_MAX;
      r_sec <= C_SEC_LOAD;
    end else if (en && (r_sec != '0)) begin
      if (r_pre == '0) begin
        r_pre <= C_PRE_MAX;
        r_sec <= r_sec - SW'(1);
      end else begin
        r_pre <= r_pre - PW'(1);
      end
    end
  end

  // Flags the cycle on which the count is about to reach zero.
  assign expired      = en && (r_pre == '0) && (r_sec == SW'(1));
  assign seconds_left = r_sec;

endmodule

`default_nettype wire

// File: rtl/move_sequencer.sv
// ============================================================================
// Module : move_sequencer
// Brief  : Per-turn countdown, move validation, board write and FSM report.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module move_sequencer
  import move_sequencer_pkg::*;
#(
  parameter int N_CELLS      = DEFAULT_N_CELLS,
  parameter int SEC_CYCLES   = 50_000_000,
  parameter int TURN_SECONDS = 10
) (
  input  wire logic     clk,
  input  wire logic     rst,
  move_sequencer_if.slave bus
);

  localparam int            CW     = $clog2(N_CELLS);
  localparam int            SW     = $clog2(TURN_SECONDS + 1);
  localparam logic [CW-1:0] C_LAST = CW'(N_CELLS - 1);

  seq_state_t    r_state, w_next;
  logic          r_player, w_player_d;
  logic [CW-1:0] r_cell, w_cell_d;
  logic [CW-1:0] r_scan_idx, w_scan_d;
  logic          r_manual, w_manual_d;
  logic          r_sel_err, w_sel_err_d;
  logic          w_load, w_en, w_expired, w_sel_ok;
  logic [SW-1:0] w_seconds;
  logic [(1<<CW)-1:0] w_occ_ext;

  turn_timer #(
    .SEC_CYCLES   (SEC_CYCLES),
    .TURN_SECONDS (TURN_SECONDS),
    .SW           (SW)
  ) u_turn_timer (
    .clk          (clk),
    .rst          (rst),
    .load         (w_load),
    .en           (w_en),
    .seconds_left (w_seconds),
    .expired      (w_expired)
  );

  // Indices past the board read as occupied so they can never be chosen.
  always_comb begin
    w_occ_ext = '1;
    for (int i = 0; i < N_CELLS; i++) begin
      w_occ_ext[i] = bus.board_occ[i];
    end
  end

  assign w_sel_ok = (32'(bus.sel_cell) < N_CELLS) && !w_occ_ext[bus.sel_cell];
  assign w_en     = (r_state == S_ARMED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_player   <= 1'b0;
      r_cell     <= '0;
      r_scan_idx <= '0;
      r_manual   <= 1'b0;
      r_sel_err  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_player   <= w_player_d;
      r_cell     <= w_cell_d;
      r_scan_idx <= w_scan_d;
      r_manual   <= w_manual_d;
      r_sel_err  <= w_sel_err_d;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_player_d  = r_player;
    w_cell_d    = r_cell;
    w_scan_d    = r_scan_idx;
    w_manual_d  = r_manual;
    w_sel_err_d = 1'b0;
    w_load      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.turn_active) begin
          w_load     = 1'b1;
          w_player_d = bus.player_id;
          w_manual_d = 1'b0;
          w_next     = S_ARMED;
        end
      end
      S_ARMED: begin
        if (!bus.turn_active) begin
          w_next = S_IDLE;
        end else if (bus.sel_valid && w_sel_ok) begin
          // A legal choice beats a simultaneous expiry.
          w_cell_d   = bus.sel_cell;
          w_manual_d = 1'b1;
          w_next     = S_WRITE;
        end else begin
          w_sel_err_d = bus.sel_valid;
          if (w_expired) begin
            w_scan_d = '0;
            w_next   = S_SCAN;
          end
        end
      end
      S_WRITE: begin
        w_next = bus.turn_active ? S_NOTIFY : S_IDLE;
      end
      S_SCAN: begin
        if (!bus.turn_active) begin
          w_next = S_IDLE;
        end else if (!w_occ_ext[r_scan_idx]) begin
          w_cell_d   = r_scan_idx;
          w_manual_d = 1'b0;
          w_next     = S_WRITE;
        end else if (r_scan_idx == C_LAST) begin
          w_manual_d = 1'b0;
          w_next     = S_NOTIFY;
        end else begin
          w_scan_d = r_scan_idx + CW'(1);
        end
      end
      S_NOTIFY: begin
        w_next = S_DONE;
      end
      S_DONE: begin
        // Wait for the game FSM to hand the turn over before re-arming.
        if (!bus.turn_active || (bus.player_id != r_player)) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign bus.wr_en        = (r_state == S_WRITE);
  assign bus.wr_cell      = (r_state == S_WRITE) ? r_cell : '0;
  assign bus.wr_player    = (r_state == S_WRITE) ? r_player : 1'b0;
  assign bus.player_mov   = (r_state == S_NOTIFY) &&  r_manual;
  assign bus.timer_out    = (r_state == S_NOTIFY) && !r_manual;
  assign bus.sel_err      = r_sel_err;
  assign bus.seconds_left = (r_state == S_IDLE) ? '0 : w_seconds;

endmodule

`default_nettype wire

// File: tb/tb_move_sequencer.sv
// ============================================================================
// Module : tb_move_sequencer
// Brief  : Directed self-checking bench for move_sequencer (4-cycle seconds).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_move_sequencer;

  localparam int N_CELLS      = 9;
  localparam int SEC_CYCLES   = 4;
  localparam int TURN_SECONDS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  move_sequencer_if #(.N_CELLS(N_CELLS), .TURN_SECONDS(TURN_SECONDS)) bus ();

  move_sequencer #(
    .N_CELLS      (N_CELLS),
    .SEC_CYCLES   (SEC_CYCLES),
    .TURN_SECONDS (TURN_SECONDS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " wr_en"},      32'(bus.wr_en),        0);
    check({tag, " player_mov"}, 32'(bus.player_mov),   0);
    check({tag, " timer_out"},  32'(bus.timer_out),    0);
    check({tag, " sel_err"},    32'(bus.sel_err),      0);
    check({tag, " seconds"},    32'(bus.seconds_left), 0);
  endtask

  initial begin
    bus.turn_active = 1'b0;
    bus.player_id   = 1'b0;
    bus.sel_valid   = 1'b0;
    bus.sel_cell    = '0;
    bus.board_occ   = '0;
    tick();
    tick();
    check_quiet("reset");
    rst = 1'b0;

    // 1: manual move by player 1 on a free cell.
    bus.turn_active = 1'b1;
    tick();
    check("t1 armed seconds", 32'(bus.seconds_left), 3);
    bus.sel_valid = 1'b1;
    bus.sel_cell  = 4'd4;
    tick();
    bus.sel_valid = 1'b0;
    check("t1 wr_en",      32'(bus.wr_en),      1);
    check("t1 wr_cell",    32'(bus.wr_cell),    4);
    check("t1 wr_player",  32'(bus.wr_player),  0);
    check("t1 early mov",  32'(bus.player_mov), 0);
    tick();
    check("t1 player_mov", 32'(bus.player_mov), 1);
    check("t1 timer_out",  32'(bus.timer_out),  0);
    check("t1 wr_en off",  32'(bus.wr_en),      0);
    tick();
    check("t1 mov pulse",  32'(bus.player_mov), 0);
    check("t1 done hold",  32'(bus.seconds_left), 3);

    // Player switch re-arms through IDLE.
    bus.player_id = 1'b1;
    tick();
    check("t1 idle seconds", 32'(bus.seconds_left), 0);
    tick();
    check("t2 rearm seconds", 32'(bus.seconds_left), 3);

    // 2: occupied cell, then out-of-range cell.
    bus.board_occ = 9'b000000100;
    bus.sel_valid = 1'b1;
    bus.sel_cell  = 4'd2;
    tick();
    check("t2 err occupied", 32'(bus.sel_err), 1);
    check("t2 no write a",   32'(bus.wr_en),   0);
    bus.sel_cell = 4'd9;
    tick();
    bus.sel_valid = 1'b0;
    check("t2 err range",    32'(bus.sel_err), 1);
    check("t2 no write b",   32'(bus.wr_en),   0);
    tick();
    check("t2 err cleared",  32'(bus.sel_err), 0);
    tick();
    check("t2 seconds 2",    32'(bus.seconds_left), 2);

    // 6b: dropping turn_active in ARMED aborts silently.
    bus.turn_active = 1'b0;
    tick();
    check_quiet("t6 abort");

    // 3: timeout with cells 0..2 taken, auto-play cell 3.
    bus.player_id   = 1'b0;
    bus.board_occ   = 9'b000000111;
    bus.turn_active = 1'b1;
    tick();
    check("t3 seconds k0", 32'(bus.seconds_left), 3);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("t3 seconds k%0d", k), 32'(bus.seconds_left),
            (k >= 12) ? 32'd0 : 32'(3 - k / 4));
    end
    for (int k = 13; k <= 15; k++) begin
      tick();
      check($sformatf("t3 scan no write k%0d", k), 32'(bus.wr_en), 0);
    end
    tick();
    check("t3 wr_en",     32'(bus.wr_en),     1);
    check("t3 wr_cell",   32'(bus.wr_cell),   3);
    check("t3 wr_player", 32'(bus.wr_player), 0);
    tick();
    check("t3 timer_out", 32'(bus.timer_out),  1);
    check("t3 no mov",    32'(bus.player_mov), 0);
    tick();
    check("t3 timer pulse", 32'(bus.timer_out), 0);

    // 4: full board at expiry, no write at all.
    bus.player_id = 1'b1;
    bus.board_occ = '1;
    tick();
    tick();
    for (int k = 1; k <= 22; k++) begin
      tick();
      check($sformatf("t4 wr_en k%0d", k), 32'(bus.wr_en), 0);
      check($sformatf("t4 timer_out k%0d", k), 32'(bus.timer_out), (k == 21) ? 32'd1 : 32'd0);
    end

    // 5: legal selection in the expiry cycle wins.
    bus.player_id = 1'b0;
    bus.board_occ = '0;
    tick();
    tick();
    for (int k = 1; k <= 11; k++) tick();
    check("t5 last second", 32'(bus.seconds_left), 1);
    bus.sel_valid = 1'b1;
    bus.sel_cell  = 4'd8;
    tick();
    bus.sel_valid = 1'b0;
    check("t5 wr_en",      32'(bus.wr_en),      1);
    check("t5 wr_cell",    32'(bus.wr_cell),    8);
    tick();
    check("t5 player_mov", 32'(bus.player_mov), 1);
    check("t5 no timeout", 32'(bus.timer_out),  0);
    tick();
    check("t5 after",      32'(bus.timer_out),  0);

    // 6a: asynchronous reset while scanning.
    bus.player_id = 1'b1;
    bus.board_occ = '1;
    tick();
    tick();
    for (int k = 1; k <= 14; k++) tick();
    check("t6 scanning seconds", 32'(bus.seconds_left), 0);
    rst = 1'b1;
    #2;
    check_quiet("t6 async rst");
    tick();
    rst = 1'b0;
    tick();
    check("t6 rearm seconds", 32'(bus.seconds_left), 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
